// File: rtl/ccff_pkg.sv
// Shared types and constants for the configuration-chain writer.
// Holds the FSM state encoding, CRC-16-CCITT constants and default geometry.
package ccff_pkg;

    localparam int DEFAULT_WORD_W    = 32;
    localparam int DEFAULT_CHAIN_LEN = 64;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_CRC_CHK = 3'd3,
        ST_DONE    = 3'd4
    } ccff_wr_state_t;

    // One MSB-first, non-reflected CRC-16 step for a single serial bit.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// Bit-serial CRC-16-CCITT accumulator, one bit per enabled clock.
// clear and reset both return the register to the init value.
module ccff_crc16_serial
    import ccff_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc16_step(crc, din);
        end
    end

endmodule

// File: rtl/ccff_chain_writer.sv
// Serialises parallel configuration words MSB-first into a CCFF chain.
// Optional CRC check of the shifted stream is built when CCFF_CRC_EN is defined.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for start; outputs quiet
// LOAD     | cfg_ready high, waiting for the next configuration word
// SHIFT    | driving one bit per cycle onto ccff_head with ccff_shift_en
// CRC_CHK  | cfg_ready high, waiting for the expected-CRC word
// DONE     | one-cycle done pulse, then back to IDLE
module ccff_chain_writer
    import ccff_pkg::*;
#(
    parameter int WORD_W    = DEFAULT_WORD_W,
    parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_word,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done
`ifdef CCFF_CRC_EN
    ,
    output logic              crc_err
`endif
);

    localparam int WC_W = $clog2(WORD_W + 1);
    localparam logic [15:0]     LAST_BIT  = 16'(CHAIN_LEN - 1);
    localparam logic [WC_W-1:0] LAST_WBIT = WC_W'(WORD_W - 1);

`ifdef CCFF_CRC_EN
    localparam ccff_wr_state_t END_STATE = ST_CRC_CHK;
`else
    localparam ccff_wr_state_t END_STATE = ST_DONE;
`endif

    ccff_wr_state_t state, state_nxt;

    logic [15:0]       bit_cnt;
    logic [WC_W-1:0]   word_cnt;
    logic [WORD_W-1:0] shreg;
    logic              xfer;
    logic              chain_end;
    logic              word_end;

    assign xfer      = cfg_valid & cfg_ready;
    assign chain_end = (bit_cnt == LAST_BIT);
    assign word_end  = (word_cnt == LAST_WBIT);

    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (start) state_nxt = ST_LOAD;
                ST_LOAD:    if (xfer) state_nxt = ST_SHIFT;
                // A short final word ends on chain_end before word_end.
                ST_SHIFT: begin
                    if (chain_end) begin
                        state_nxt = END_STATE;
                    end else if (word_end) begin
                        state_nxt = ST_LOAD;
                    end
                end
                ST_CRC_CHK: if (xfer) state_nxt = ST_DONE;
                ST_DONE:    state_nxt = ST_IDLE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cfg_ready     = (state == ST_LOAD) || (state == ST_CRC_CHK);
        ccff_shift_en = (state == ST_SHIFT) && !abort;
        ccff_head     = (state == ST_SHIFT) && !abort && shreg[WORD_W-1];
        busy          = (state != ST_IDLE);
        done          = (state == ST_DONE) && !abort;
    end

    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            bit_cnt  <= '0;
            word_cnt <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) bit_cnt <= '0;
                end
                ST_LOAD: begin
                    if (xfer && !abort) begin
                        shreg    <= cfg_word;
                        word_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (!abort) begin
                        shreg    <= shreg << 1;
                        bit_cnt  <= bit_cnt + 16'd1;
                        word_cnt <= word_cnt + WC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CCFF_CRC_EN
    logic [15:0] crc;
    logic [15:0] crc_ref;
    logic        crc_err_q;

    ccff_crc16_serial u_crc (
        .clk     (prog_clk),
        .reset_n (prog_reset_n),
        .clear   (state == ST_IDLE),
        .en      (ccff_shift_en),
        .din     (ccff_head),
        .crc     (crc)
    );

    // Narrow words carry a zero-extended reference CRC.
    generate
        if (WORD_W >= 16) begin : g_ref_wide
            assign crc_ref = cfg_word[15:0];
        end else begin : g_ref_narrow
            assign crc_ref = 16'(cfg_word);
        end
    endgenerate

    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            crc_err_q <= 1'b0;
        end else if (state == ST_CRC_CHK && xfer && !abort) begin
            crc_err_q <= (crc_ref != crc);
        end
    end

    assign crc_err = done && crc_err_q;
`endif

endmodule

// File: tb/tb_ccff_chain_writer.sv
// Directed bench for ccff_chain_writer: 8/16 and 8/20 chains, plus a 16/16
// chain exercising the CRC check when CCFF_CRC_EN is defined.
module tb_ccff_chain_writer;
    import ccff_pkg::*;

`ifdef CCFF_CRC_EN
    localparam int CRC_EXTRA = 1;
`else
    localparam int CRC_EXTRA = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_v [2];
    logic       abort_v [2];
    logic       valid_v [2];
    logic [7:0] word_v  [2];
    logic ready_a, head_a, sh_a, busy_a, done_a;
    logic ready_b, head_b, sh_b, busy_b, done_b;
    logic crc_err_a, crc_err_b;

    int errors = 0;
    int checks = 0;

    ccff_chain_writer #(.WORD_W(8), .CHAIN_LEN(16)) dut_a (
        .prog_clk(clk), .prog_reset_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
        .cfg_word(word_v[0]), .cfg_valid(valid_v[0]), .cfg_ready(ready_a),
        .ccff_head(head_a), .ccff_shift_en(sh_a), .busy(busy_a), .done(done_a)
`ifdef CCFF_CRC_EN
        , .crc_err(crc_err_a)
`endif
    );

    ccff_chain_writer #(.WORD_W(8), .CHAIN_LEN(20)) dut_b (
        .prog_clk(clk), .prog_reset_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
        .cfg_word(word_v[1]), .cfg_valid(valid_v[1]), .cfg_ready(ready_b),
        .ccff_head(head_b), .ccff_shift_en(sh_b), .busy(busy_b), .done(done_b)
`ifdef CCFF_CRC_EN
        , .crc_err(crc_err_b)
`endif
    );

`ifdef CCFF_CRC_EN
    logic        start_c, abort_c, valid_c;
    logic [15:0] word_c;
    logic        ready_c, head_c, sh_c, busy_c, done_c, crc_err_c;

    ccff_chain_writer #(.WORD_W(16), .CHAIN_LEN(16)) dut_c (
        .prog_clk(clk), .prog_reset_n(rst_n), .start(start_c), .abort(abort_c),
        .cfg_word(word_c), .cfg_valid(valid_c), .cfg_ready(ready_c),
        .ccff_head(head_c), .ccff_shift_en(sh_c), .busy(busy_c), .done(done_c),
        .crc_err(crc_err_c)
    );

    function automatic logic [15:0] crc_model(input logic [15:0] d);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = (c << 1) ^ 16'h1021;
            else              c = c << 1;
        end
        return c;
    endfunction
`endif

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int sel, output logic r, output logic h, output logic s,
                          output logic b, output logic d);
        if (sel == 0) begin
            r = ready_a; h = head_a; s = sh_a; b = busy_a; d = done_a;
        end else begin
            r = ready_b; h = head_b; s = sh_b; b = busy_b; d = done_b;
        end
    endtask

    // Drives one full load and records what the chain saw; callers check the results.
    task automatic run_load(input int sel, input int nw, input logic [7:0] w0,
                            input logic [7:0] w1, input logic [7:0] w2, input int stall_n,
                            output logic [31:0] bits, output int nshift, output int ndone,
                            output int done_cyc, output logic busy_after,
                            output logic done_after, output int stall_shifts,
                            output logic timed_out);
        logic [7:0] words [3];
        int   idx, stall_left;
        logic r, h, s, b, d, seen, stall_prev;
        words[0] = w0; words[1] = w1; words[2] = w2;
        bits = '0; nshift = 0; ndone = 0; done_cyc = -1; busy_after = 1'b1;
        done_after = 1'b1; stall_shifts = 0; timed_out = 1'b1;
        seen = 1'b0; stall_prev = 1'b0; idx = 0; stall_left = stall_n;
        start_v[sel] = 1'b1;
        tick;
        start_v[sel] = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            sample(sel, r, h, s, b, d);
            if (seen) begin
                busy_after = b; done_after = d; timed_out = 1'b0;
                break;
            end
            if (stall_prev && s) stall_shifts++;
            if (s) begin
                bits = {bits[30:0], h};
                nshift++;
            end
            if (d) begin
                ndone++; done_cyc = cyc; seen = 1'b1;
            end
            stall_prev = 1'b0;
            if (r && idx == 1 && stall_left > 0) begin
                valid_v[sel] = 1'b0;
                stall_left--;
                stall_prev = 1'b1;
            end else begin
                valid_v[sel] = (idx < nw + CRC_EXTRA);
                word_v[sel]  = (idx < nw) ? words[idx] : 8'h00;
            end
            if (r && valid_v[sel]) idx++;
            tick;
        end
        valid_v[sel] = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0; abort_v[i] = 1'b0; valid_v[i] = 1'b0; word_v[i] = 8'h00;
        end
`ifdef CCFF_CRC_EN
        start_c = 1'b0; abort_c = 1'b0; valid_c = 1'b0; word_c = 16'h0000;
`endif
        tick; tick; tick;
        checks++;
        if ({ready_a, head_a, sh_a, busy_a, done_a} !== 5'b0) begin
            errors++;
            $display("FAIL reset_during_a: outputs=%b expected 00000", {ready_a, head_a, sh_a, busy_a, done_a});
        end
        rst_n = 1'b1;
        tick;
        checks++;
        if ({ready_a, head_a, sh_a, busy_a, done_a} !== 5'b0) begin
            errors++;
            $display("FAIL reset_after_a: outputs=%b expected 00000", {ready_a, head_a, sh_a, busy_a, done_a});
        end
        checks++;
        if ({ready_b, head_b, sh_b, busy_b, done_b} !== 5'b0) begin
            errors++;
            $display("FAIL reset_after_b: outputs=%b expected 00000", {ready_b, head_b, sh_b, busy_b, done_b});
        end
        checks++;
        if (dut_a.state !== ST_IDLE || dut_a.bit_cnt !== 16'd0 || dut_a.shreg !== 8'h00) begin
            errors++;
            $display("FAIL reset_regs: state=%0d bit_cnt=%0d shreg=%h expected 0 0 00",
                     dut_a.state, dut_a.bit_cnt, dut_a.shreg);
        end
`ifdef CCFF_CRC_EN
        checks++;
        if (dut_a.crc !== 16'hFFFF || crc_err_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_crc: crc=%h crc_err=%b expected ffff 0", dut_a.crc, crc_err_a);
        end
`endif
    endtask

    task automatic test_basic_load;
        logic [31:0] bits; int nshift, ndone, done_cyc, stall_shifts;
        logic busy_after, done_after, to;
        run_load(0, 2, 8'hA5, 8'h3C, 8'h00, 0, bits, nshift, ndone, done_cyc,
                 busy_after, done_after, stall_shifts, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout: done never seen"); end
        checks++;
        if (bits !== 32'h0000A53C) begin
            errors++; $display("FAIL basic_head_seq: got %h expected 0000a53c", bits);
        end
        checks++;
        if (nshift !== 16) begin errors++; $display("FAIL basic_shift_cnt: got %0d expected 16", nshift); end
        checks++;
        if (ndone !== 1 || done_after !== 1'b0) begin
            errors++; $display("FAIL basic_done_once: dones=%0d next=%b expected 1 0", ndone, done_after);
        end
        checks++;
        if (busy_after !== 1'b0) begin errors++; $display("FAIL basic_busy_fall: got %b expected 0", busy_after); end
        checks++;
        if (done_cyc !== 18 + CRC_EXTRA) begin
            errors++; $display("FAIL basic_latency: got %0d expected %0d", done_cyc, 18 + CRC_EXTRA);
        end
    endtask

    task automatic test_partial_word;
        logic [31:0] bits; int nshift, ndone, done_cyc, stall_shifts;
        logic busy_after, done_after, to;
        run_load(1, 3, 8'hFF, 8'h00, 8'hB7, 0, bits, nshift, ndone, done_cyc,
                 busy_after, done_after, stall_shifts, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL partial_timeout: done never seen"); end
        checks++;
        if (nshift !== 20) begin errors++; $display("FAIL partial_shift_cnt: got %0d expected 20", nshift); end
        checks++;
        if (bits !== 32'h000FF00B) begin
            errors++; $display("FAIL partial_head_seq: got %h expected 000ff00b", bits);
        end
        checks++;
        if (done_cyc !== 23 + CRC_EXTRA) begin
            errors++; $display("FAIL partial_latency: got %0d expected %0d", done_cyc, 23 + CRC_EXTRA);
        end
        checks++;
        if (busy_after !== 1'b0) begin errors++; $display("FAIL partial_busy_fall: got %b expected 0", busy_after); end
    endtask

    task automatic test_stall;
        logic [31:0] bits; int nshift, ndone, done_cyc, stall_shifts;
        logic busy_after, done_after, to;
        run_load(0, 2, 8'hA5, 8'h3C, 8'h00, 5, bits, nshift, ndone, done_cyc,
                 busy_after, done_after, stall_shifts, to);
        checks++;
        if (stall_shifts !== 0) begin
            errors++; $display("FAIL stall_no_shift: got %0d shifts expected 0", stall_shifts);
        end
        checks++;
        if (bits !== 32'h0000A53C || nshift !== 16) begin
            errors++; $display("FAIL stall_head_seq: got %h/%0d expected 0000a53c/16", bits, nshift);
        end
        checks++;
        if (done_cyc !== 23 + CRC_EXTRA) begin
            errors++; $display("FAIL stall_latency: got %0d expected %0d", done_cyc, 23 + CRC_EXTRA);
        end
    endtask

    task automatic test_abort;
        logic [31:0] bits; int nshift, ndone, done_cyc, stall_shifts, stray;
        logic busy_after, done_after, to;
        start_v[0] = 1'b1; valid_v[0] = 1'b1; word_v[0] = 8'hA5;
        tick;
        start_v[0] = 1'b0;
        tick; tick; tick;
        checks++;
        if (sh_a !== 1'b1) begin errors++; $display("FAIL abort_pre_shift: got %b expected 1", sh_a); end
        abort_v[0] = 1'b1;
        #1;
        checks++;
        if (sh_a !== 1'b0 || done_a !== 1'b0) begin
            errors++; $display("FAIL abort_same_cycle: shift_en=%b done=%b expected 0 0", sh_a, done_a);
        end
        tick;
        abort_v[0] = 1'b0; valid_v[0] = 1'b0;
        checks++;
        if (dut_a.state !== ST_IDLE || busy_a !== 1'b0 || sh_a !== 1'b0) begin
            errors++; $display("FAIL abort_idle: state=%0d busy=%b shift_en=%b expected 0 0 0",
                               dut_a.state, busy_a, sh_a);
        end
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            if (done_a || sh_a) stray++;
            tick;
        end
        checks++;
        if (stray !== 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles expected 0", stray); end
        run_load(0, 2, 8'hA5, 8'h3C, 8'h00, 0, bits, nshift, ndone, done_cyc,
                 busy_after, done_after, stall_shifts, to);
        checks++;
        if (bits !== 32'h0000A53C || nshift !== 16 || ndone !== 1) begin
            errors++; $display("FAIL abort_reload: got %h/%0d/%0d expected 0000a53c/16/1", bits, nshift, ndone);
        end
    endtask

    task automatic test_reset_mid_load;
        int stray;
        start_v[0] = 1'b1; valid_v[0] = 1'b1; word_v[0] = 8'h5A;
        tick;
        start_v[0] = 1'b0;
        tick; tick; tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1; valid_v[0] = 1'b0;
        checks++;
        if ({ready_a, head_a, sh_a, busy_a, done_a} !== 5'b0 || dut_a.state !== ST_IDLE) begin
            errors++; $display("FAIL midreset_outputs: outputs=%b state=%0d expected 00000 0",
                               {ready_a, head_a, sh_a, busy_a, done_a}, dut_a.state);
        end
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (sh_a || busy_a) stray++;
        end
        checks++;
        if (stray !== 0) begin errors++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", stray); end
    endtask

`ifdef CCFF_CRC_EN
    task automatic run_crc(input logic [15:0] crc_word, input logic exp_err, input string tag);
        logic seen;
        seen = 1'b0;
        start_c = 1'b1; valid_c = 1'b1; word_c = 16'hA53C;
        tick;
        start_c = 1'b0;
        tick;
        word_c = crc_word;
        for (int i = 0; i < 40; i++) begin
            if (done_c) begin seen = 1'b1; break; end
            tick;
        end
        valid_c = 1'b0;
        checks++;
        if (seen !== 1'b1 || crc_err_c !== exp_err) begin
            errors++; $display("FAIL crc_%s: done=%b crc_err=%b expected 1 %b", tag, seen, crc_err_c, exp_err);
        end
        tick;
        checks++;
        if (done_c !== 1'b0 || crc_err_c !== 1'b0 || busy_c !== 1'b0) begin
            errors++; $display("FAIL crc_%s_after: done=%b crc_err=%b busy=%b expected 0 0 0",
                               tag, done_c, crc_err_c, busy_c);
        end
    endtask

    task automatic test_crc;
        logic [15:0] exp_crc;
        exp_crc = crc_model(16'hA53C);
        run_crc(exp_crc, 1'b0, "good");
        run_crc(exp_crc ^ 16'h0001, 1'b1, "bad");
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_basic_load;
        test_partial_word;
        test_stall;
        test_abort;
        test_reset_mid_load;
`ifdef CCFF_CRC_EN
        test_crc;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
